// File: rtl/vertices_fetch_unit_pkg.sv
// Shared constants for the vertex ROM, fetch unit and rasterizer.
// ROM words pack {x0,y0,x1,y1} from MSB to LSB.
package vertices_fetch_unit_pkg;

  localparam int COORD_W = 13;
  localparam int DATA_W  = 4 * COORD_W;
  localparam int ADDR_W  = 8;

  localparam int X0_FLD = 3;
  localparam int Y0_FLD = 2;
  localparam int X1_FLD = 1;
  localparam int Y1_FLD = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } state_t;

  function automatic int fld_lsb(input int fld, input int cw);
    return fld * cw;
  endfunction

endpackage

// File: rtl/vertices_fetch_unit_if.sv
// Line segment handshake from the fetch unit to the rasterizer.
// Coordinates describe the head entry while line_valid is high.
interface vertices_fetch_unit_if
  import vertices_fetch_unit_pkg::*;
#(
  parameter int COORD_WIDTH = COORD_W
);

  logic                   line_valid;
  logic                   line_ready;
  logic [COORD_WIDTH-1:0] line_x0;
  logic [COORD_WIDTH-1:0] line_y0;
  logic [COORD_WIDTH-1:0] line_x1;
  logic [COORD_WIDTH-1:0] line_y1;

  modport master (
    output line_valid,
    output line_x0,
    output line_y0,
    output line_x1,
    output line_y1,
    input  line_ready
  );

  modport slave (
    input  line_valid,
    input  line_x0,
    input  line_y0,
    input  line_x1,
    input  line_y1,
    output line_ready
  );

endinterface

// File: rtl/vertices_fetch_unit_line_skid_fifo.sv
// Two-entry FIFO holding ROM words between capture and handshake.
// Head is read straight from storage so it stays put while stalled.
module line_skid_fifo #(
  parameter int WIDTH = 52,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  logic [WIDTH-1:0] mem [2];
  logic             wp;
  logic             rp;

  assign head = mem[rp];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (pop) begin
        rp <= ~rp;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    push |-> (count != FULL)
  );

endmodule

// File: rtl/vertices_fetch_unit.sv
// Walks the vertex ROM 0..last_addr, absorbs its read latency and
// hands one unpacked line segment per entry to the rasterizer.
module vertices_fetch_unit
  import vertices_fetch_unit_pkg::*;
#(
  parameter int COORD_WIDTH = COORD_W,
  parameter int DATA_WIDTH  = DATA_W,
  parameter int ADDR_WIDTH  = ADDR_W,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_q,
  vertices_fetch_unit_if.master line,
  output logic                  busy,
  output logic                  done
);

  localparam int X0_LSB = fld_lsb(X0_FLD, COORD_WIDTH);
  localparam int Y0_LSB = fld_lsb(Y0_FLD, COORD_WIDTH);
  localparam int X1_LSB = fld_lsb(X1_FLD, COORD_WIDTH);
  localparam int Y1_LSB = fld_lsb(Y1_FLD, COORD_WIDTH);

  state_t                state;
  logic [ADDR_WIDTH-1:0] last_q;
  logic                  inflight;
  logic [1:0]            cnt;
  logic [DATA_WIDTH-1:0] head;
  logic                  pop;
  logic                  issue;
  logic [2:0]            occ;

  assign pop   = line.line_valid & line.line_ready;
  // Occupancy after this cycle's pop; capped so the FIFO cannot overflow.
  assign occ   = 3'(cnt) + 3'(inflight) - 3'(pop);
  assign issue = (state == S_FETCH) && (occ < 3'(FIFO_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      rom_addr <= '0;
      last_q   <= '0;
      inflight <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= issue;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            last_q   <= last_addr;
            rom_addr <= '0;
            busy     <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (issue) begin
            if (rom_addr == last_q) begin
              state <= S_DRAIN;
            end else begin
              rom_addr <= rom_addr + ADDR_WIDTH'(1);
            end
          end
        end
        S_DRAIN: begin
          if (!inflight && occ == 3'd0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  line_skid_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .pop   (pop),
    .din   (rom_q),
    .count (cnt),
    .head  (head)
  );

  assign line.line_valid = (cnt != 2'd0);
  assign line.line_x0    = head[X0_LSB +: COORD_WIDTH];
  assign line.line_y0    = head[Y0_LSB +: COORD_WIDTH];
  assign line.line_x1    = head[X1_LSB +: COORD_WIDTH];
  assign line.line_y1    = head[Y1_LSB +: COORD_WIDTH];

endmodule
